data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the core data-memory interface: cores issue write_en/address/data requests; this block owns the shared data RAM and answers them.
- Arbitrates NUM_CORES cores onto one single-port RAM with round-robin fairness.
- Provides a host preload port for loading matrices before cores run.
- Returns read data with fixed 1-cycle latency and a per-core valid strobe.

Parameters:
- NUM_CORES, 2, number of requesting cores (≥1).
- ADDR_W, 8, address width, matching the cores' data address.
- DATA_W, 16, word width, matching the cores' data bus.
- DEPTH, 256, implemented words (≤ 2**ADDR_W).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- host_we  in  1  host write strobe; highest priority.
- host_addr  in  ADDR_W  host write address.
- host_wdata  in  DATA_W  host write data.
- req  in  NUM_CORES  per-core request; held until granted.
- we  in  NUM_CORES  per-core write (1) / read (0) qualifier.
- addr  in  NUM_CORES*ADDR_W  packed addresses; core i uses slice i.
- wdata  in  NUM_CORES*DATA_W  packed write data.
- gnt  out  NUM_CORES  one-hot grant, combinational, same cycle.
- rvalid  out  NUM_CORES  one-hot: rdata belongs to core i this cycle.
- rdata  out  DATA_W  registered read data, shared by all cores.

Behaviour:
- Reset (async assert, sync release):
  - rvalid=0, rdata=0.
  - rr_ptr=NUM_CORES-1, so core 0 wins first.
  - RAM contents are not reset.
- Cycle priority:
  - host_we=1 → RAM[host_addr]<=host_wdata at the edge; gnt=0; rr_ptr unchanged.
  - Otherwise, scan cores from rr_ptr+1 modulo NUM_CORES; the first with req=1 gets gnt. gnt is combinational from req, host_we and rr_ptr.
  - At most one gnt bit per cycle; gnt=0 while reset is asserted.
- Granted write: RAM[addr_i]<=wdata_i at the edge; no rvalid.
- Granted read: RAM[addr_i] is registered into rdata at the edge; rvalid[i]=1 for exactly the next cycle.
- rdata holds its last value when no read is in flight.
- Arbiter state:
  - rr_ptr<=i on every core grant.
  - rr_ptr is unchanged on idle or host cycles.
- Back-to-back reads to different cores pipeline at 1 per cycle; rvalid follows gnt by exactly one cycle.
- Out-of-range addresses (addr ≥ DEPTH, host or core):
  - Writes are ignored.
  - Reads return 0 with rvalid still asserted.
  - The request is still granted.
- Read and write in the same cycle are impossible (single port). A read the cycle after a write to the same address returns the new data.
- A core dropping req without a grant is legal; nothing is recorded.
- Reset mid-read kills the pending rvalid, and no stale strobe appears after release.
- Width rules: no arithmetic on data; rr_ptr is $clog2(NUM_CORES) bits (min 1) with explicit wrap to 0.

Decomposition:
- Shared package holds:
  - DATA_W/ADDR_W defaults, shared with the core wiring.
  - A localparam function for pointer width.
- One natural sub-module: rr_arbiter.
  - Inputs: req, enable(=!host_we), rr_ptr.
  - Outputs: one-hot gnt and encoded index.
  - Purely combinational; rr_ptr register stays in the parent.
- RAM is an inferred reg array inside data_mem_responder (single write port, synchronous read).

Test Plan:
1. Reset then host writes 0x1234 to addr 5; core0 reads 5 → gnt[0] same cycle; next cycle rvalid=01, rdata=0x1234.
2. Cores 0 and 1 both hold req continuously with reads of addrs 1 and 2 → grants alternate 0,1,0,1; rvalid alternates one cycle later with matching data.
3. host_we=1 while both cores request → gnt=00 that cycle; after host drops, grant goes to the core after rr_ptr.
4. Core1 writes 0xBEEF to addr 9 and is granted; core0 reads 9 the next cycle → rdata=0xBEEF.
5. DEPTH=200: core0 writes 0xFFFF to addr 210, then reads 210 → rdata=0x0000 with rvalid[0]=1; no RAM word changed.
6. Assert reset in the cycle after a granted read → rvalid stays 0, rdata=0; after release, core0 wins first.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder and the core-side wiring.
//   DATA_W_DEF / ADDR_W_DEF : default bus widths, must match the cores
//   NUM_CORES_DEF / DEPTH_DEF: default core count and implemented word count
//   ptr_w()                  : width of a round-robin pointer (never below 1)
package data_mem_responder_pkg;

   localparam int unsigned DATA_W_DEF    = 16;
   localparam int unsigned ADDR_W_DEF    = 8;
   localparam int unsigned NUM_CORES_DEF = 2;
   localparam int unsigned DEPTH_DEF     = 256;

   // $clog2(1) is 0, which would give a zero-width pointer.
   function automatic int unsigned ptr_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Core/host request bus into the shared data RAM.
//   host_we/host_addr/host_wdata : host preload write port
//   req/we/addr/wdata            : per-core requests, addr/wdata packed (core i = slice i)
//   gnt                          : one-hot combinational grant
//   rvalid/rdata                 : one-hot read strobe and shared registered read data
// master = cores/host side, slave = responder side.
interface data_mem_responder_if
   import data_mem_responder_pkg::*;
#(
   parameter int unsigned NUM_CORES = NUM_CORES_DEF,
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned DATA_W    = DATA_W_DEF
) ();

   logic                          host_we;
   logic [ADDR_W-1:0]             host_addr;
   logic [DATA_W-1:0]             host_wdata;
   logic [NUM_CORES-1:0]          req;
   logic [NUM_CORES-1:0]          we;
   logic [NUM_CORES*ADDR_W-1:0]   addr;
   logic [NUM_CORES*DATA_W-1:0]   wdata;
   logic [NUM_CORES-1:0]          gnt;
   logic [NUM_CORES-1:0]          rvalid;
   logic [DATA_W-1:0]             rdata;

   modport master (
      output host_we, host_addr, host_wdata, req, we, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  host_we, host_addr, host_wdata, req, we, addr, wdata,
      output gnt, rvalid, rdata
   );

endinterface

// File: rtl/data_mem_responder_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req    : per-requester request
//   enable : 0 forces no grant (host cycle or reset)
//   rr_ptr : index of the last winner; scan starts at rr_ptr+1
//   gnt    : one-hot grant
//   idx    : encoded index of the granted requester
//   any    : a grant was issued
module data_mem_responder_rr_arbiter
   import data_mem_responder_pkg::*;
#(
   parameter int unsigned NUM_CORES = NUM_CORES_DEF,
   parameter int unsigned PW        = ptr_w(NUM_CORES)
) (
   input  logic [NUM_CORES-1:0] req,
   input  logic                 enable,
   input  logic [PW-1:0]        rr_ptr,
   output logic [NUM_CORES-1:0] gnt,
   output logic [PW-1:0]        idx,
   output logic                 any
);

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int k = 1; k <= int'(NUM_CORES); k++) begin
         int c;
         c = int'(rr_ptr) + k;
         if (c >= int'(NUM_CORES)) begin
            c = c - int'(NUM_CORES);
         end
         if (enable && !any && req[c]) begin
            gnt[c] = 1'b1;
            idx    = PW'(c);
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder owning the shared single-port data RAM.
// Host preload writes take priority; otherwise cores are served round-robin,
// one access per cycle. Reads return on rdata one cycle after the grant with
// a one-hot rvalid naming the owning core.
//   clock : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : slave side of data_mem_responder_if (host port, core requests,
//           gnt/rvalid/rdata)
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int unsigned NUM_CORES = NUM_CORES_DEF,
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned DEPTH     = DEPTH_DEF
) (
   input  logic                  clock,
   input  logic                  reset,
   data_mem_responder_if.slave   bus
);

   localparam int unsigned PW = ptr_w(NUM_CORES);
   localparam int unsigned MW = ptr_w(DEPTH);

   logic [DATA_W-1:0]    mem [DEPTH];

   logic [PW-1:0]        rr_ptr_q;
   logic [NUM_CORES-1:0] rvalid_q;
   logic [DATA_W-1:0]    rdata_q;

   logic [NUM_CORES-1:0] gnt;
   logic [PW-1:0]        gnt_idx;
   logic                 gnt_any;

   logic [ADDR_W-1:0]    sel_addr;
   logic [DATA_W-1:0]    sel_wdata;
   logic                 sel_we;
   logic                 sel_in_range;
   logic                 host_in_range;

   data_mem_responder_rr_arbiter #(
      .NUM_CORES (NUM_CORES),
      .PW        (PW)
   ) u_arb (
      .req    (bus.req),
      .enable (!bus.host_we && !reset),
      .rr_ptr (rr_ptr_q),
      .gnt    (gnt),
      .idx    (gnt_idx),
      .any    (gnt_any)
   );

   always_comb begin
      sel_addr      = bus.addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
      sel_wdata     = bus.wdata[int'(gnt_idx)*DATA_W +: DATA_W];
      sel_we        = bus.we[gnt_idx];
      sel_in_range  = 32'(sel_addr) < DEPTH;
      host_in_range = 32'(bus.host_addr) < DEPTH;
   end

   // Single write port: host and granted core never write in the same cycle
   // because gnt is forced low on host cycles. Out-of-range writes are dropped.
   always_ff @(posedge clock) begin
      if (bus.host_we) begin
         if (host_in_range) begin
            mem[bus.host_addr[MW-1:0]] <= bus.host_wdata;
         end
      end else if (gnt_any && sel_we && sel_in_range) begin
         mem[sel_addr[MW-1:0]] <= sel_wdata;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr_ptr_q <= PW'(NUM_CORES - 1);
         rvalid_q <= '0;
         rdata_q  <= '0;
      end else begin
         if (gnt_any) begin
            rr_ptr_q <= gnt_idx;
         end
         if (gnt_any && !sel_we) begin
            rvalid_q <= gnt;
            rdata_q  <= sel_in_range ? mem[sel_addr[MW-1:0]] : '0;
         end else begin
            rvalid_q <= '0;
         end
      end
   end

   assign bus.gnt    = gnt;
   assign bus.rvalid = rvalid_q;
   assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: 2 cores, 8-bit addresses, 16-bit data,
// 200 implemented words so out-of-range addresses can be exercised.
module tb_data_mem_responder;

   logic clock;
   logic reset;
   int   total;
   int   bad;

   data_mem_responder_if #(
      .NUM_CORES (2),
      .ADDR_W    (8),
      .DATA_W    (16)
   ) bus ();

   data_mem_responder #(
      .NUM_CORES (2),
      .ADDR_W    (8),
      .DATA_W    (16),
      .DEPTH     (200)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s got=%b want=%b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s got=%h want=%h", tag, obs, exp);
      end
   endtask

   task automatic set_core(input int c, input logic w, input logic [7:0] a,
                           input logic [15:0] d);
      bus.we[c]           = w;
      bus.addr[c*8 +: 8]  = a;
      bus.wdata[c*16 +: 16] = d;
   endtask

   task automatic host_write(input logic [7:0] a, input logic [15:0] d);
      bus.host_we    = 1'b1;
      bus.host_addr  = a;
      bus.host_wdata = d;
      tick();
      bus.host_we    = 1'b0;
   endtask

   logic [1:0]  exp_g [4];
   logic [15:0] exp_d [4];

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.host_we    = 1'b0;
      bus.host_addr  = '0;
      bus.host_wdata = '0;
      bus.req        = 2'b11;
      bus.we         = '0;
      bus.addr       = '0;
      bus.wdata      = '0;
      #2;
      // Reset state, including no grant while reset is held.
      chk2("reset_gnt", bus.gnt, 2'b00);
      chk2("reset_rvalid", bus.rvalid, 2'b00);
      chk16("reset_rdata", bus.rdata, 16'h0000);
      bus.req = 2'b00;
      tick();
      reset = 1'b0;

      // 1: host preload, then core0 read. Core0 wins first out of reset.
      bus.host_we = 1'b1; bus.host_addr = 8'd5; bus.host_wdata = 16'h1234;
      bus.req = 2'b01;
      #1;
      chk2("t1_host_gnt", bus.gnt, 2'b00);
      tick();
      bus.host_we = 1'b0;
      set_core(0, 1'b0, 8'd5, 16'h0000);
      #1;
      chk2("t1_gnt", bus.gnt, 2'b01);
      tick();
      bus.req = 2'b00;
      chk2("t1_rvalid", bus.rvalid, 2'b01);
      chk16("t1_rdata", bus.rdata, 16'h1234);

      host_write(8'd1, 16'h1111);
      chk2("t1_rvalid_drop", bus.rvalid, 2'b00);
      chk16("t1_rdata_hold", bus.rdata, 16'h1234);
      host_write(8'd2, 16'h2222);

      // 2: both cores read continuously; last winner was core0 so core1 goes first.
      set_core(0, 1'b0, 8'd1, 16'h0000);
      set_core(1, 1'b0, 8'd2, 16'h0000);
      bus.req = 2'b11;
      exp_g[0] = 2'b10; exp_d[0] = 16'h2222;
      exp_g[1] = 2'b01; exp_d[1] = 16'h1111;
      exp_g[2] = 2'b10; exp_d[2] = 16'h2222;
      exp_g[3] = 2'b01; exp_d[3] = 16'h1111;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk2($sformatf("t2_gnt%0d", i), bus.gnt, exp_g[i]);
         tick();
         chk2($sformatf("t2_rvalid%0d", i), bus.rvalid, exp_g[i]);
         chk16($sformatf("t2_rdata%0d", i), bus.rdata, exp_d[i]);
      end

      // 3: host cycle blocks both cores; pointer stays at core0.
      bus.host_we = 1'b1; bus.host_addr = 8'd3; bus.host_wdata = 16'h3333;
      #1;
      chk2("t3_host_gnt", bus.gnt, 2'b00);
      tick();
      bus.host_we = 1'b0;
      chk2("t3_host_rvalid", bus.rvalid, 2'b00);
      #1;
      chk2("t3_gnt", bus.gnt, 2'b10);
      tick();
      bus.req = 2'b00;
      chk2("t3_rvalid", bus.rvalid, 2'b10);
      chk16("t3_rdata", bus.rdata, 16'h2222);

      // 4: core1 writes, core0 reads it back the next cycle.
      set_core(1, 1'b1, 8'd9, 16'hBEEF);
      bus.req = 2'b10;
      #1;
      chk2("t4_wr_gnt", bus.gnt, 2'b10);
      tick();
      chk2("t4_wr_rvalid", bus.rvalid, 2'b00);
      chk16("t4_rdata_hold", bus.rdata, 16'h2222);
      set_core(0, 1'b0, 8'd9, 16'h0000);
      bus.req = 2'b01;
      #1;
      chk2("t4_rd_gnt", bus.gnt, 2'b01);
      tick();
      chk2("t4_rvalid", bus.rvalid, 2'b01);
      chk16("t4_rdata", bus.rdata, 16'hBEEF);

      // 5: out-of-range write is granted but dropped; read returns 0.
      set_core(0, 1'b1, 8'd210, 16'hFFFF);
      #1;
      chk2("t5_wr_gnt", bus.gnt, 2'b01);
      tick();
      set_core(0, 1'b0, 8'd210, 16'h0000);
      #1;
      chk2("t5_rd_gnt", bus.gnt, 2'b01);
      tick();
      chk2("t5_rvalid", bus.rvalid, 2'b01);
      chk16("t5_rdata", bus.rdata, 16'h0000);
      set_core(1, 1'b0, 8'd9, 16'h0000);
      bus.req = 2'b10;
      tick();
      chk2("t5_chk_rvalid", bus.rvalid, 2'b10);
      chk16("t5_chk_rdata", bus.rdata, 16'hBEEF);

      // 6: reset while the read result is pending kills the strobe and data.
      set_core(0, 1'b0, 8'd5, 16'h0000);
      bus.req = 2'b01;
      #1;
      chk2("t6_gnt", bus.gnt, 2'b01);
      tick();
      bus.req = 2'b00;
      reset = 1'b1;
      #1;
      chk2("t6_rst_rvalid", bus.rvalid, 2'b00);
      chk16("t6_rst_rdata", bus.rdata, 16'h0000);
      tick();
      reset = 1'b0;
      tick();
      chk2("t6_post_rvalid", bus.rvalid, 2'b00);
      set_core(0, 1'b0, 8'd1, 16'h0000);
      set_core(1, 1'b0, 8'd2, 16'h0000);
      bus.req = 2'b11;
      #1;
      chk2("t6_first_gnt", bus.gnt, 2'b01);
      tick();
      bus.req = 2'b00;
      chk2("t6_first_rvalid", bus.rvalid, 2'b01);
      chk16("t6_first_rdata", bus.rdata, 16'h1111);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
